attack_phase_controller: RTL and testbench
==========================================

# attack_phase_controller

Sequential producer of the 2-bit attack phase consumed by the character renderer, and the gameplay-side owner of the same 32×8 hitbox geometry the renderer draws. Converts a player attack request into a frame-timed Startup → Active → Recovery sequence, advanced by a per-frame tick. During Active it tests the hitbox against the opponent's hurtbox and emits at most one hit pulse per attack. One instance sits per character between input handling and the renderer/health logic.

## Interface
- STARTUP_FRAMES, 5, frames spent in Startup (1..63)
- ACTIVE_FRAMES, 3, frames spent in Active (1..63)
- RECOVERY_FRAMES, 8, frames spent in Recovery (1..63)
- HITBOX_WIDTH, 32, hitbox width in pixels
- HITBOX_HEIGHT, 8, hitbox height in pixels
- clk  in  1  system clock; the only clock
- rst  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse, once per video frame
- attack_req  in  1  level attack button, already synchronized to clk
- stun_in  in  1  level; aborts or blocks attacks while high
- char_x_pos_in, char_y_pos_in  in  10 each  own body top-left
- char_width_in, char_height_in  in  10 each  own body size
- opp_x_pos_in, opp_y_pos_in  in  10 each  opponent hurtbox top-left
- opp_width_in, opp_height_in  in  10 each  opponent hurtbox size
- attack_phase_out  out  2  00 idle, 01 startup, 10 active, 11 recovery
- attack_busy_out  out  1  high whenever phase ≠ 00
- hit_out  out  1  one-cycle pulse on first hitbox/hurtbox overlap of an attack

## Operation
- States: IDLE(00), STARTUP(01), ACTIVE(10), RECOVERY(11); attack_phase_out is the state encoding, registered.
- Edge detect: req_prev registered each clk; request edge = attack_req & ~req_prev.
- IDLE → STARTUP when request edge and stun_in low; frame counter loaded with STARTUP_FRAMES; hit_done cleared.
- In STARTUP/ACTIVE/RECOVERY: on frame_tick, if counter == 1 advance (STARTUP→ACTIVE loading ACTIVE_FRAMES, ACTIVE→RECOVERY loading RECOVERY_FRAMES, RECOVERY→IDLE), else counter − 1. No change without frame_tick.
- Request edges outside IDLE are discarded (no buffering); holding attack_req through RECOVERY does not re-trigger.
- stun_in high: any state → IDLE next clk, counter cleared; stun beats a simultaneous request edge.
- Hitbox geometry (10-bit modular arithmetic, truncating, no saturation, identical to renderer): left = x + w; right = left + HITBOX_WIDTH − 1; top = y + (h >> 1) − (HITBOX_HEIGHT >> 1); bottom = top + HITBOX_HEIGHT − 1.
- Opponent: right = ox + ow − 1, bottom = oy + oh − 1. Overlap = hb_left ≤ opp_right & opp_x ≤ hb_right & hb_top ≤ opp_bottom & opp_y ≤ hb_bottom (inclusive edges; unsigned compare).
- In ACTIVE with overlap and hit_done = 0: hit_out = 1 next cycle, hit_done set. hit_out never asserts outside ACTIVE or twice per attack.

## Timing
- Reset values: state IDLE, attack_phase_out 00, attack_busy_out 0, hit_out 0, counter 0, hit_done 0, req_prev 0.
- Request edge at cycle N → attack_phase_out = 01 at N+1.
- Phase durations count frame_ticks: STARTUP ends on the STARTUP_FRAMES-th tick after entry; the first frame is partial.
- Phase change is visible the cycle after the terminal frame_tick.
- Overlap detected in cycle N (state ACTIVE) → hit_out high at N+1 only.
- frame_tick coincident with stun_in: stun wins, IDLE.
- Reset mid-attack: IDLE next cycle, pending hit discarded.

## Test plan
- Defaults (5/3/8): request edge, ticks every 100 clks → phase 01 for 5 ticks, 10 for 3, 11 for 8, then 00; busy tracks phase ≠ 00.
- Char (100,200,40,60), opp (150,220,30,40): hitbox x 140..171, y 226..233 overlaps → one hit_out pulse in ACTIVE; opp moved to x=172 → no pulse.
- Overlap held through all 3 ACTIVE frames → exactly one hit_out; second attack → one more.
- Request edge during RECOVERY and held attack_req → ignored; new edge after IDLE starts fresh STARTUP.
- stun_in asserted in ACTIVE → phase 00 next clk, no hit_out; request edge with stun high → stays 00.
- rst asserted mid-STARTUP → all outputs 0 next clk; wrap case x=1000, w=30 → hitbox left wraps to 6, overlap checked against wrapped values.

Source files
------------

// File: rtl/attack_phase_controller.sv
// Frame-timed attack sequencer: Startup -> Active -> Recovery driven by frame_tick,
// with a single hit pulse per attack when the 32x8 hitbox overlaps the opponent hurtbox.
module attack_phase_controller #(
  parameter int unsigned STARTUP_FRAMES  = 5,
  parameter int unsigned ACTIVE_FRAMES   = 3,
  parameter int unsigned RECOVERY_FRAMES = 8,
  parameter int unsigned HITBOX_WIDTH    = 32,
  parameter int unsigned HITBOX_HEIGHT   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       attack_req,
  input  logic       stun_in,
  input  logic [9:0] char_x_pos_in,
  input  logic [9:0] char_y_pos_in,
  input  logic [9:0] char_width_in,
  input  logic [9:0] char_height_in,
  input  logic [9:0] opp_x_pos_in,
  input  logic [9:0] opp_y_pos_in,
  input  logic [9:0] opp_width_in,
  input  logic [9:0] opp_height_in,
  output logic [1:0] attack_phase_out,
  output logic       attack_busy_out,
  output logic       hit_out
);

  localparam int unsigned POS_W = 10;
  localparam int unsigned CNT_W = 6;

  localparam logic [POS_W-1:0] HB_W_M1   = POS_W'(HITBOX_WIDTH - 1);
  localparam logic [POS_W-1:0] HB_H_M1   = POS_W'(HITBOX_HEIGHT - 1);
  localparam logic [POS_W-1:0] HB_H_HALF = POS_W'(HITBOX_HEIGHT / 2);

  localparam logic [CNT_W-1:0] CNT_STARTUP  = CNT_W'(STARTUP_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ACTIVE   = CNT_W'(ACTIVE_FRAMES);
  localparam logic [CNT_W-1:0] CNT_RECOVERY = CNT_W'(RECOVERY_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    STARTUP  = 2'b01,
    ACTIVE   = 2'b10,
    RECOVERY = 2'b11
  } phase_e;

  phase_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit_done_q, hit_done_d;
  logic             req_prev_q, req_prev_d;
  logic             hit_q, hit_d;
  logic             busy_q, busy_d;

  logic [POS_W-1:0] hb_left, hb_right, hb_top, hb_bottom;
  logic [POS_W-1:0] opp_right, opp_bottom;
  logic             overlap;
  logic             req_edge;

  // Hitbox geometry wraps modulo 1024 exactly like the renderer's copy.
  always_comb begin
    hb_left    = char_x_pos_in + char_width_in;
    hb_right   = hb_left + HB_W_M1;
    hb_top     = char_y_pos_in + (char_height_in >> 1) - HB_H_HALF;
    hb_bottom  = hb_top + HB_H_M1;
    opp_right  = opp_x_pos_in + opp_width_in - POS_W'(1);
    opp_bottom = opp_y_pos_in + opp_height_in - POS_W'(1);
    overlap    = (hb_left <= opp_right) && (opp_x_pos_in <= hb_right) &&
                 (hb_top <= opp_bottom) && (opp_y_pos_in <= hb_bottom);
  end

  assign req_edge = attack_req & ~req_prev_q;

  // Next-state: stun overrides everything, otherwise frame ticks walk the phases.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hit_done_d = hit_done_q;
    hit_d      = 1'b0;
    req_prev_d = attack_req;

    if (stun_in) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_edge) begin
            state_d    = STARTUP;
            cnt_d      = CNT_STARTUP;
            hit_done_d = 1'b0;
          end
        end
        STARTUP: begin
          if (frame_tick) begin
            if (cnt_q == CNT_ONE) begin
              state_d = ACTIVE;
              cnt_d   = CNT_ACTIVE;
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end
        end
        ACTIVE: begin
          if (overlap && !hit_done_q) begin
            hit_d      = 1'b1;
            hit_done_d = 1'b1;
          end
          if (frame_tick) begin
            if (cnt_q == CNT_ONE) begin
              state_d = RECOVERY;
              cnt_d   = CNT_RECOVERY;
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end
        end
        RECOVERY: begin
          if (frame_tick) begin
            if (cnt_q == CNT_ONE) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      hit_done_q <= 1'b0;
      req_prev_q <= 1'b0;
      hit_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hit_done_q <= hit_done_d;
      req_prev_q <= req_prev_d;
      hit_q      <= hit_d;
      busy_q     <= busy_d;
    end
  end

  assign attack_phase_out = state_q;
  assign attack_busy_out  = busy_q;
  assign hit_out          = hit_q;

endmodule

// File: tb/tb_attack_phase_controller.sv
// Scoreboard bench for attack_phase_controller: a behavioural model predicts phase, busy
// and hit for every cycle; predictions are queued at drive time and checked a cycle later.
module tb_attack_phase_controller;

  logic       clk = 1'b0;
  logic       rst, frame_tick, attack_req, stun_in;
  logic [9:0] cx, cy, cw, ch, ox, oy, ow, oh;
  logic [1:0] attack_phase_out;
  logic       attack_busy_out, hit_out;

  always #5 clk = ~clk;

  attack_phase_controller dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .attack_req(attack_req), .stun_in(stun_in),
    .char_x_pos_in(cx), .char_y_pos_in(cy), .char_width_in(cw), .char_height_in(ch),
    .opp_x_pos_in(ox), .opp_y_pos_in(oy), .opp_width_in(ow), .opp_height_in(oh),
    .attack_phase_out(attack_phase_out), .attack_busy_out(attack_busy_out), .hit_out(hit_out)
  );

  typedef struct {
    logic [1:0] phase;
    logic       busy;
    logic       hit;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   hits_seen = 0;

  // stimulus levels applied on each step
  bit req_lvl = 0, stun_lvl = 0, rst_lvl = 1;
  int period = 100;
  int tcnt = 0;

  // reference model state (value after the upcoming posedge)
  int m_state = 0, m_cnt = 0, m_hit_done = 0, m_req_prev = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_overlap();
    int hl, hr, ht, hb, orr, ob;
    hl  = (int'(cx) + int'(cw)) & 1023;
    hr  = (hl + 31) & 1023;
    ht  = (int'(cy) + (int'(ch) / 2) - 4) & 1023;
    hb  = (ht + 7) & 1023;
    orr = (int'(ox) + int'(ow) - 1) & 1023;
    ob  = (int'(oy) + int'(oh) - 1) & 1023;
    return (hl <= orr) && (int'(ox) <= hr) && (ht <= ob) && (int'(oy) <= hb);
  endfunction

  task automatic model_update(input bit tick);
    bit edge_r, ov, nh;
    exp_t e;
    nh = 0;
    if (rst_lvl) begin
      m_state = 0; m_cnt = 0; m_hit_done = 0; m_req_prev = 0;
    end else begin
      edge_r = req_lvl && (m_req_prev == 0);
      ov = model_overlap();
      if (stun_lvl) begin
        m_state = 0; m_cnt = 0;
      end else if (m_state == 0) begin
        if (edge_r) begin m_state = 1; m_cnt = 5; m_hit_done = 0; end
      end else begin
        if (m_state == 2 && ov && m_hit_done == 0) begin nh = 1; m_hit_done = 1; end
        if (tick) begin
          if (m_cnt == 1) begin
            m_cnt   = (m_state == 1) ? 3 : (m_state == 2) ? 8 : 0;
            m_state = (m_state == 3) ? 0 : m_state + 1;
          end else begin
            m_cnt = m_cnt - 1;
          end
        end
      end
      m_req_prev = req_lvl;
    end
    e.phase = 2'(m_state);
    e.busy  = (m_state != 0);
    e.hit   = nh;
    sb_q.push_back(e);
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("phase", 32'(attack_phase_out), 32'(e.phase));
      check("busy", 32'(attack_busy_out), 32'(e.busy));
      check("hit", 32'(hit_out), 32'(e.hit));
      if (hit_out === 1'b1) hits_seen++;
    end
  endtask

  task automatic step();
    bit tick;
    @(negedge clk);
    compare_out();
    tick = (tcnt % period) == (period - 1);
    tcnt++;
    frame_tick = tick;
    attack_req = req_lvl;
    stun_in    = stun_lvl;
    rst        = rst_lvl;
    model_update(tick);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_until(input int st, input int bound);
    int i;
    for (i = 0; i < bound && m_state != st; i++) step();
    if (m_state != st) check("wait_timeout", 32'(attack_phase_out), 32'(st));
  endtask

  task automatic attack_edge();
    req_lvl = 0; step();
    req_lvl = 1; tcnt = 0; step();
    req_lvl = 0;
  endtask

  task automatic set_geom(input int x, input int y, input int w, input int h,
                          input int px, input int py, input int pw, input int ph);
    cx = 10'(x); cy = 10'(y); cw = 10'(w); ch = 10'(h);
    ox = 10'(px); oy = 10'(py); ow = 10'(pw); oh = 10'(ph);
  endtask

  initial begin
    rst = 1; frame_tick = 0; attack_req = 0; stun_in = 0;
    set_geom(100, 200, 40, 60, 150, 220, 30, 40);

    // reset
    rst_lvl = 1; run(3);
    rst_lvl = 0; run(2);
    check("reset_phase", 32'(attack_phase_out), 0);

    // full sequence at default timing with overlapping geometry
    hits_seen = 0; period = 100;
    attack_edge();
    run(1700);
    check("seq_hits", 32'(hits_seen), 1);
    check("seq_end_phase", 32'(attack_phase_out), 0);

    // opponent just past hitbox right edge
    period = 10;
    set_geom(100, 200, 40, 60, 172, 220, 30, 40);
    hits_seen = 0; attack_edge(); run(200);
    check("miss_hits", 32'(hits_seen), 0);

    // overlap restored: second attack gives exactly one more hit
    set_geom(100, 200, 40, 60, 150, 220, 30, 40);
    hits_seen = 0; attack_edge(); run(200);
    check("second_hits", 32'(hits_seen), 1);

    // edges and held request during recovery are ignored
    attack_edge();
    run_until(3, 300);
    run(3);
    req_lvl = 1;
    run_until(0, 300);
    run(5);
    check("held_idle", 32'(attack_phase_out), 0);
    req_lvl = 0; step();
    req_lvl = 1; tcnt = 0; step(); step();
    check("restart", 32'(attack_phase_out), 1);
    req_lvl = 0; run(200);

    // stun on first active cycle: back to idle, no hit
    hits_seen = 0; attack_edge();
    run_until(2, 300);
    stun_lvl = 1; step(); step();
    check("stun_phase", 32'(attack_phase_out), 0);
    check("stun_hits", 32'(hits_seen), 0);
    // request edge while stunned stays idle
    req_lvl = 1; step(); step();
    check("stun_block", 32'(attack_phase_out), 0);
    req_lvl = 0; stun_lvl = 0; run(3);

    // reset mid-startup
    attack_edge(); run(3);
    rst_lvl = 1; step(); step();
    check("rst_mid_phase", 32'(attack_phase_out), 0);
    check("rst_mid_busy", 32'(attack_busy_out), 0);
    rst_lvl = 0; run(3);

    // wrapped hitbox: left = 6, right = 37
    set_geom(1000, 200, 30, 60, 10, 220, 30, 40);
    hits_seen = 0; attack_edge(); run(200);
    check("wrap_hit", 32'(hits_seen), 1);
    set_geom(1000, 200, 30, 60, 38, 220, 30, 40);
    hits_seen = 0; attack_edge(); run(200);
    check("wrap_miss", 32'(hits_seen), 0);

    // random soak with stun, ticks and request toggles
    set_geom(100, 200, 40, 60, 150, 220, 30, 40);
    period = 7;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) req_lvl = ~req_lvl;
      stun_lvl = ($urandom_range(0, 40) == 0);
      step();
    end
    stun_lvl = 0; req_lvl = 0;
    run(2);
    @(negedge clk);
    compare_out();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
